// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, reads the async ROM and buffers {pc, instr} in a DEPTH-entry queue.
// Optional combinational ROM-to-decode bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       INSTR_W  = 10,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic [ADDR_W-1:0]        o_imem_addr,
    input  logic [INSTR_W-1:0]       i_imem_rdata,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [INSTR_W-1:0]       o_out_instr,
    output logic [ADDR_W-1:0]        o_out_pc,
    input  logic                     i_redirect,
    input  logic [ADDR_W-1:0]        i_redirect_pc,
    input  logic                     i_halt,
    output logic                     o_halted,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_halted;

    logic w_flush;
    logic w_q_valid;
    logic w_q_pop;
    logic w_fetch_ok;
    logic w_push;
    logic w_advance;

    // A redirect after halt must not disturb the draining queue.
    assign w_flush    = i_redirect & ~r_halted;
    assign w_q_valid  = (r_count != '0);
    assign w_q_pop    = w_q_valid & i_out_ready;
    assign w_fetch_ok = ~r_halted & ~i_halt & ~i_redirect
                        & ((r_count < CNT_W'(DEPTH)) | w_q_pop);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;

    assign w_bypass  = ~w_q_valid & ~r_halted & ~i_halt & ~i_redirect;
    // A bypassed instruction consumed this cycle advances the PC but never enters storage.
    assign w_push    = w_fetch_ok & ~(w_bypass & i_out_ready);
    assign w_advance = w_fetch_ok;

    always_comb begin
        o_out_valid = w_q_valid | w_bypass;
        o_out_instr = r_instr_mem[r_rd_ptr];
        o_out_pc    = r_pc_mem[r_rd_ptr];
        if (w_bypass) begin
            o_out_instr = i_imem_rdata;
            o_out_pc    = r_fetch_pc;
        end
    end
`else
    assign w_push    = w_fetch_ok;
    assign w_advance = w_fetch_ok;

    always_comb begin
        o_out_valid = w_q_valid;
        o_out_instr = r_instr_mem[r_rd_ptr];
        o_out_pc    = r_pc_mem[r_rd_ptr];
    end
`endif

    assign o_imem_addr = r_fetch_pc;
    assign o_halted    = r_halted;
    assign o_count     = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_halted   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else begin
            r_halted <= r_halted | i_halt;
            if (w_flush) begin
                r_fetch_pc <= i_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
                    r_instr_mem[r_wr_ptr] <= i_imem_rdata;
                    r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                end
                if (w_q_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_advance) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_q_pop);
            end
        end
    end

endmodule
